disp_scan_ctrl: RTL

DISP_SCAN_CTRL -- requirements
Module: disp_scan_ctrl

---
 rtl/disp_scan_ctrl_if.sv | 40 ++++
 rtl/disp_scan_ctrl.sv | 130 +++++++++++++
 2 files changed

// File: rtl/disp_scan_ctrl_if.sv
// ---------------------------------------------------------------------------
// disp_scan_ctrl_if
// Frame-load bus into the display scan controller.
//
// Handshake: a frame transfers on a rising clk edge where load_valid and
// load_ready are both 1. The producer holds load_digits/load_dp/load_en
// stable while load_valid is high. load_ready may drop without a transfer.
// load_valid may be withdrawn at any time without a transfer.
//
// Signals:
//   load_valid   producer offers a frame
//   load_ready   controller can accept a frame this cycle
//   load_digits  [3:0] digit 1 .. [15:12] digit 4
//   load_dp      decimal-point request, bit n-1 = digit n
//   load_en      digit enable mask, bit n-1 = digit n
// Modports: master = producer side, slave = controller side.
// ---------------------------------------------------------------------------
interface disp_scan_ctrl_if;
   logic        load_valid;
   logic        load_ready;
   logic [15:0] load_digits;
   logic [3:0]  load_dp;
   logic [3:0]  load_en;

   modport master (
      output load_valid,
      output load_digits,
      output load_dp,
      output load_en,
      input  load_ready
   );

   modport slave (
      input  load_valid,
      input  load_digits,
      input  load_dp,
      input  load_en,
      output load_ready
   );
endinterface

// File: rtl/disp_scan_ctrl.sv
// ---------------------------------------------------------------------------
// disp_scan_ctrl
// Four-digit multiplexed display scanner with a double-buffered frame load.
// Each digit is held for SCAN_DIV clk cycles; digits are visited 1,2,3,4,1...
// A loaded frame waits in a shadow buffer and becomes the active frame at the
// next frame boundary (terminal count while digit 4 is shown).
//
// Ports:
//   clk         sole clock, rising edge
//   rst         asynchronous, active-high reset
//   load        frame-load bus (disp_scan_ctrl_if.slave)
//   showDigit   index of the digit being driven, 1..4
//   showNum     {dp, 1'b0, value} of that digit, 0 when the digit is disabled
//   frame_tick  one-cycle pulse after each frame boundary edge
// ---------------------------------------------------------------------------
module disp_scan_ctrl #(
   parameter int unsigned SCAN_DIV = 16384
) (
   input  logic             clk,
   input  logic             rst,
   disp_scan_ctrl_if.slave  load,
   output logic [3:0]       showDigit,
   output logic [5:0]       showNum,
   output logic             frame_tick
);

   localparam int unsigned PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam logic [PW-1:0] TC = PW'(SCAN_DIV - 1);

   logic [PW-1:0] presc_q, presc_d;
   logic [1:0]    idx_q, idx_d;          // 0-based digit index
   logic [15:0]   act_digits_q, act_digits_d;
   logic [3:0]    act_dp_q, act_dp_d;
   logic [3:0]    act_en_q, act_en_d;
   logic [15:0]   shd_digits_q, shd_digits_d;
   logic [3:0]    shd_dp_q, shd_dp_d;
   logic [3:0]    shd_en_q, shd_en_d;
   logic          pend_q, pend_d;
   logic [3:0]    show_digit_q, show_digit_d;
   logic [5:0]    show_num_q, show_num_d;
   logic          frame_tick_q, frame_tick_d;

   logic          tc;
   logic          boundary;
   logic          accept;
   logic [3:0]    sel_val;

   assign load.load_ready = ~pend_q;

   always_comb begin
      tc           = (presc_q == TC);
      boundary     = tc && (idx_q == 2'd3);
      accept       = load.load_valid && !pend_q;

      presc_d      = tc ? '0 : presc_q + 1'b1;
      idx_d        = tc ? idx_q + 2'd1 : idx_q;   // 3 -> 0 wraps naturally

      act_digits_d = act_digits_q;
      act_dp_d     = act_dp_q;
      act_en_d     = act_en_q;
      shd_digits_d = shd_digits_q;
      shd_dp_d     = shd_dp_q;
      shd_en_d     = shd_en_q;
      pend_d       = pend_q;

      // accept and swap are mutually exclusive: accept needs pend_q = 0,
      // a swap needs pend_q = 1.
      if (accept) begin
         shd_digits_d = load.load_digits;
         shd_dp_d     = load.load_dp;
         shd_en_d     = load.load_en;
         pend_d       = 1'b1;
      end
      if (boundary && pend_q) begin
         act_digits_d = shd_digits_q;
         act_dp_d     = shd_dp_q;
         act_en_d     = shd_en_q;
         pend_d       = 1'b0;
      end

      frame_tick_d = boundary;

      // Outputs are built from the next index and next active buffer so the
      // new digit (and a freshly swapped frame) appear on the same edge.
      show_digit_d = {2'b00, idx_d} + 4'd1;
      sel_val      = 4'd0;
      case (idx_d)
         2'd0:    sel_val = act_digits_d[3:0];
         2'd1:    sel_val = act_digits_d[7:4];
         2'd2:    sel_val = act_digits_d[11:8];
         default: sel_val = act_digits_d[15:12];
      endcase
      show_num_d   = act_en_d[idx_d] ? {act_dp_d[idx_d], 1'b0, sel_val} : 6'd0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc_q      <= '0;
         idx_q        <= 2'd0;
         act_digits_q <= 16'd0;
         act_dp_q     <= 4'd0;
         act_en_q     <= 4'd0;
         shd_digits_q <= 16'd0;
         shd_dp_q     <= 4'd0;
         shd_en_q     <= 4'd0;
         pend_q       <= 1'b0;
         show_digit_q <= 4'd1;
         show_num_q   <= 6'd0;
         frame_tick_q <= 1'b0;
      end else begin
         presc_q      <= presc_d;
         idx_q        <= idx_d;
         act_digits_q <= act_digits_d;
         act_dp_q     <= act_dp_d;
         act_en_q     <= act_en_d;
         shd_digits_q <= shd_digits_d;
         shd_dp_q     <= shd_dp_d;
         shd_en_q     <= shd_en_d;
         pend_q       <= pend_d;
         show_digit_q <= show_digit_d;
         show_num_q   <= show_num_d;
         frame_tick_q <= frame_tick_d;
      end
   end

   assign showDigit  = show_digit_q;
   assign showNum    = show_num_q;
   assign frame_tick = frame_tick_q;

endmodule
